// File: rtl/sample_loader.sv
// sample_loader: packs a byte stream into 64-bit input-memory words at {index, level}, then launches one sample at a time.
// Latency: wr_en one cycle after a word's 8th byte; start one cycle after the last write (after the trailer byte with SAMPLE_LOADER_CHKSUM_EN).
// Backpressure: in_ready low during WRITE, LAUNCH and WAIT; the producer holds in_data until it is accepted.
module sample_loader #(
  parameter int NUM_WORDS   = 8,
  parameter int MAX_SAMPLES = 1024,
  localparam int LVL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int IDX_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [IDX_W+LVL_W-1:0] wr_addr,
  output logic [63:0]            wr_data,
  output logic                   start,
  input  logic                   finish,
  output logic [IDX_W-1:0]       index,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_WRITE,
`ifdef SAMPLE_LOADER_CHKSUM_EN
    ST_CHECK,
`endif
    ST_LAUNCH,
    ST_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        byte_cnt_q;
  logic [LVL_W-1:0]  level_q;
  logic [63:0]       word_q, word_d;
  logic              xfer, last_byte, last_level, idx_wrap;

  assign xfer       = in_valid & in_ready;
  assign last_byte  = (byte_cnt_q == 3'd7);
  assign last_level = (level_q == LVL_W'(NUM_WORDS - 1));
  assign idx_wrap   = (index == IDX_W'(MAX_SAMPLES - 1));

  // Word as it will look once the byte on in_data lands in its lane.
  always_comb begin
    word_d = word_q;
    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
  end

`ifdef SAMPLE_LOADER_CHKSUM_EN
  logic [7:0] sum_q;
  logic       trailer_ok;

  assign trailer_ok = (in_data == sum_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= 8'd0;
      err   <= 1'b0;
    end else if (state_q == ST_FILL && xfer) begin
      sum_q <= sum_q + in_data;
    end else if (state_q == ST_CHECK && xfer) begin
      // Either outcome starts a fresh sample, so the sum restarts here.
      sum_q <= 8'd0;
      if (!trailer_ok) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:   if (xfer && last_byte) state_d = ST_WRITE;
      ST_WRITE: begin
        if (last_level) begin
`ifdef SAMPLE_LOADER_CHKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_LAUNCH;
`endif
        end else begin
          state_d = ST_FILL;
        end
      end
`ifdef SAMPLE_LOADER_CHKSUM_EN
      ST_CHECK:  if (xfer) state_d = trailer_ok ? ST_LAUNCH : ST_FILL;
`endif
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (finish) state_d = ST_FILL;
      default:   state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FILL;
    else      state_q <= state_d;
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b1;
      wr_en    <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
    end else begin
`ifdef SAMPLE_LOADER_CHKSUM_EN
      in_ready <= (state_d == ST_FILL) || (state_d == ST_CHECK);
`else
      in_ready <= (state_d == ST_FILL);
`endif
      wr_en    <= (state_d == ST_WRITE);
      start    <= (state_d == ST_LAUNCH);
      busy     <= (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= 3'd0;
      word_q     <= 64'd0;
      wr_addr    <= '0;
      wr_data    <= 64'd0;
    end else if (state_q == ST_FILL && xfer) begin
      byte_cnt_q <= last_byte ? 3'd0 : byte_cnt_q + 3'd1;
      word_q     <= word_d;
      if (last_byte) begin
        wr_addr <= {index, level_q};
        wr_data <= word_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      index   <= '0;
    end else begin
      if (state_q == ST_WRITE)
        level_q <= last_level ? '0 : level_q + LVL_W'(1);
      if (state_q == ST_WAIT && finish)
        index <= idx_wrap ? '0 : index + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_loader.sv
// Bench for sample_loader: byte-level model predicts every write (address, data, cycle) and start pulse; a per-cycle monitor compares.
module tb_sample_loader;
  localparam int NUM_WORDS   = 8;
  localparam int MAX_SAMPLES = 64;
  localparam int LVL_W       = 3;
  localparam int IDX_W       = 6;
  localparam int AW          = IDX_W + LVL_W;
  localparam int NBYTES      = 8 * NUM_WORDS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             finish = 1'b0;
  logic             in_ready, wr_en, start, busy, err;
  logic [AW-1:0]    wr_addr;
  logic [63:0]      wr_data;
  logic [IDX_W-1:0] index;

  sample_loader #(.NUM_WORDS(NUM_WORDS), .MAX_SAMPLES(MAX_SAMPLES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .finish(finish),
    .index(index), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference model state
  logic [63:0]      m_word = 64'd0;
  int               m_nb = 0;
  int               m_level = 0;
  logic [7:0]       m_sum = 8'd0;
  logic [IDX_W-1:0] exp_index = '0;
  logic             exp_err = 1'b0;
  bit               pend_err = 1'b0;
  logic [AW-1:0]    exp_addr[$];
  logic [63:0]      exp_data[$];
  int               exp_wcyc[$];
  int               exp_scyc[$];
  logic [AW-1:0]    log_addr[$];
  logic [63:0]      log_data[$];
  logic [7:0]       smp[NBYTES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Per-cycle monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    check("index", index, exp_index);
    check("err", err, exp_err);
    if (!rst) check("wr_en_in_reset", wr_en, 0);
    if (busy) check("in_ready_while_busy", in_ready, 0);
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      if (exp_addr.size() == 0) fail_now("unexpected_write");
      else begin
        check("wr_addr", wr_addr, exp_addr.pop_front());
        check("wr_data", wr_data, exp_data.pop_front());
        check("wr_cycle", cyc, exp_wcyc.pop_front());
      end
    end
    if (start) begin
      if (exp_scyc.size() == 0) fail_now("unexpected_start");
      else check("start_cycle", cyc, exp_scyc.pop_front());
    end
  end

  // Offer one byte; the model is updated once the handshake is certain for the next rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit trailer);
    int guard;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      in_valid = 1'b0;
      return;
    end
    if (trailer) begin
      if (b == m_sum) exp_scyc.push_back(cyc + 1);
      else pend_err = 1'b1;
      m_sum = 8'd0;
    end else begin
      m_word[8*m_nb +: 8] = b;
      m_sum = m_sum + b;
      m_nb++;
      if (m_nb == 8) begin
        exp_addr.push_back({exp_index, LVL_W'(m_level)});
        exp_data.push_back(m_word);
        exp_wcyc.push_back(cyc + 1);
        m_nb = 0;
        if (m_level == NUM_WORDS - 1) begin
          m_level = 0;
`ifndef SAMPLE_LOADER_CHKSUM_EN
          exp_scyc.push_back(cyc + 2);
          m_sum = 8'd0;
`endif
        end else begin
          m_level++;
        end
      end
    end
    @(posedge clk);
    if (pend_err) exp_err = 1'b1;
    pend_err = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_sample(input bit gaps, input int stray_at, input int tdelta);
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == stray_at) finish = 1'b1;
      send_byte(smp[i], gaps, 1'b0);
      finish = 1'b0;
      sum = sum + smp[i];
    end
`ifdef SAMPLE_LOADER_CHKSUM_EN
    send_byte(sum + tdelta[7:0], gaps, 1'b1);
`else
    if (tdelta != 0) $display("note: trailer delta %0d ignored without checksum", tdelta);
`endif
  endtask

  task automatic wait_launch();
    int g;
    g = 0;
    while (!start && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("start_seen", start, 1);
    @(negedge clk);
  endtask

  task automatic do_finish(input int extra);
    repeat (extra) @(negedge clk);
    check("busy_before_finish", busy, 1);
    finish = 1'b1;
    @(posedge clk);
    exp_index = (exp_index == IDX_W'(MAX_SAMPLES - 1)) ? '0 : exp_index + 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("busy_after_finish", busy, 0);
    check("in_ready_after_finish", in_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_index = '0;
    exp_err = 1'b0;
    m_nb = 0;
    m_level = 0;
    m_sum = 8'd0;
    m_word = 64'd0;
    pend_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_log(input int base, input int a0, input logic [63:0] d_first, input logic [63:0] d_last);
    if (log_addr.size() < base + 8) begin
      fail_now("log_length");
    end else begin
      for (int k = 0; k < 8; k++) check("log_addr", log_addr[base+k], a0 + k);
      check("log_first_word", log_data[base], d_first);
      check("log_last_word", log_data[base+7], d_last);
    end
  endtask

  task automatic ramp();
    for (int i = 0; i < NBYTES; i++) smp[i] = i[7:0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ns;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_index", index, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Ramp 0x00..0x3F with in_valid held high
    ramp();
    base = log_addr.size();
    send_sample(1'b0, -1, 0);
    wait_launch();
    check("launch_busy", busy, 1);
    check("launch_in_ready", in_ready, 0);
    repeat (4) @(negedge clk);
    check("wait_in_ready", in_ready, 0);
    do_finish(0);
    check("index_after_finish", index, 1);
    check_log(base, 0, 64'h0706050403020100, 64'h3F3E3D3C3B3A3938);

    // Same ramp with valid gaps and a stray finish during FILL
    base = log_addr.size();
    send_sample(1'b1, 20, 0);
    wait_launch();
    do_finish(2);
    check_log(base, 8, 64'h0706050403020100, 64'h3F3E3D3C3B3A3938);

    // Random samples until the index wraps
    ns = 0;
    do begin
      for (int i = 0; i < NBYTES; i++) smp[i] = 8'($urandom);
      send_sample(1'($urandom_range(0, 1)), -1, 0);
      wait_launch();
      do_finish($urandom_range(0, 3));
      ns++;
    end while (exp_index != 0 && ns < 100);
    check("wrapped_index", index, 0);
    ramp();
    base = log_addr.size();
    send_sample(1'b0, -1, 0);
    wait_launch();
    check_log(base, 0, 64'h0706050403020100, 64'h3F3E3D3C3B3A3938);
    do_finish(1);

    // Reset after 3 bytes of word 2
    for (int i = 0; i < 19; i++) send_byte(i[7:0], 1'b0, 1'b0);
    do_reset();
    check("mid_reset_index", index, 0);
    check("mid_reset_wr_en", wr_en, 0);
    base = log_addr.size();
    send_sample(1'b0, -1, 0);
    wait_launch();
    check_log(base, 0, 64'h0706050403020100, 64'h3F3E3D3C3B3A3938);
    do_finish(0);

`ifdef SAMPLE_LOADER_CHKSUM_EN
    // 64 x 0x01 sums to 0x40
    do_reset();
    for (int i = 0; i < NBYTES; i++) smp[i] = 8'h01;
    send_sample(1'b0, -1, 0);
    wait_launch();
    do_finish(0);
    do_reset();
    base = log_addr.size();
    send_sample(1'b0, -1, 1);
    repeat (3) @(negedge clk);
    check("bad_trailer_err", err, 1);
    check("bad_trailer_busy", busy, 0);
    check("bad_trailer_in_ready", in_ready, 1);
    check_log(base, 0, 64'h0101010101010101, 64'h0101010101010101);
    base = log_addr.size();
    send_sample(1'b0, -1, 0);
    wait_launch();
    check_log(base, 0, 64'h0101010101010101, 64'h0101010101010101);
    do_finish(0);
    check("err_sticky", err, 1);
`endif

    repeat (3) @(negedge clk);
    check("pending_writes", exp_addr.size(), 0);
    check("pending_starts", exp_scyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_loader.md
# sample_loader

Front-end writer for the inference input memory. Accepts a byte stream of input features over a valid/ready handshake and packs eight bytes into each 64-bit word. Writes each word to the input memory at address {index, level}, which is the same word the datapath later reads back per level. After a full sample is written it pulses `start` to the inference controller, then waits for `finish` before accepting the next sample.

## Interface
- `NUM_WORDS`, default 8: 64-bit words per sample, equal to the number of input levels; level counter is 3 bits.
- `MAX_SAMPLES`, default 1024: sample slots in the input memory; index wraps at `MAX_SAMPLES-1`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a byte on `in_data`.
- `in_data`  in  8  feature byte.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `wr_en`  out  1  input-memory write strobe, one cycle per word.
- `wr_addr`  out  13  write address: {index[9:0], level[2:0]}.
- `wr_data`  out  64  packed word.
- `start`  out  1  one-cycle pulse to the inference controller.
- `finish`  in  1  inference done for the current sample (from the datapath).
- `index`  out  10  current sample slot.
- `busy`  out  1  high from `start` until `finish` is accepted.
- `err`  out  1  sticky checksum error; tied 0 when the feature is compiled out.

## Operation
- A byte transfers when `in_valid` and `in_ready` are both high on a rising edge.
- Byte order: the k-th accepted byte of a word goes to bits [8k+7:8k]. Word 0 is level 0.
- FSM states: FILL, WRITE, CHECK (macro only), LAUNCH, WAIT. Reset state is FILL.
- FILL
  - `in_ready`=1.
  - Each transfer stores the byte and increments the byte counter (0..7).
  - A transfer with counter==7 goes to WRITE and clears the counter.
- WRITE
  - `in_ready`=0 and `wr_en`=1 for exactly one cycle, with `wr_addr`={index, level} and `wr_data`=packed word.
  - If level==`NUM_WORDS-1`: clear level, then go to CHECK if built with the macro, else LAUNCH.
  - Otherwise: level+1, then FILL.
- LAUNCH: `start`=1 for one cycle, `busy` set, then WAIT.
- WAIT
  - `in_ready`=0.
  - On `finish`=1: clear `busy`; index+1, wrapping from `MAX_SAMPLES-1` to 0; then FILL.
- `finish` is ignored in every state except WAIT, including the LAUNCH cycle itself.
- `in_valid` without `in_ready` has no effect. The producer holds `in_data` until the transfer.

## Timing
- All outputs are registered. Reset values:
  - `in_ready`=1;
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0;
  - `start`=0, `busy`=0, `index`=0, `err`=0.
- Reset asserted mid-sample: counters and the FSM clear immediately, no write is issued, and the partial word is discarded. Index returns to 0.
- Word latency: `wr_en` asserts on the cycle after the 8th byte transfer.
- Minimum cost per word is 9 cycles (8 transfers + 1 WRITE).
- `start` asserts on the cycle after the last WRITE, or after the CHECK transfer when the macro is built.
- `wr_data` and `wr_addr` hold their last value when `wr_en`=0.

## Configuration
- Macro `SAMPLE_LOADER_CHKSUM_EN`.
- When defined:
  - An 8-bit running sum (mod 256) covers all `8*NUM_WORDS` data bytes of the sample.
  - CHECK state: `in_ready`=1, and the loader accepts one trailer byte.
  - Trailer equal to the sum: go to LAUNCH.
  - Trailer not equal: set `err`=1, which stays set until reset. Skip LAUNCH, return to FILL with the same index, so the sample slot is overwritten.
  - The sum clears at the start of each sample.
- When undefined: there is no CHECK state and no trailer byte, and `err` is constant 0.

## Test plan
- Reset, then 64 bytes 0x00..0x3F with `in_valid` held high:
  - 8 writes at `wr_addr` 0..7;
  - first `wr_data`=0x0706050403020100, last=0x3F3E3D3C3B3A3938;
  - one `start` pulse, then `in_ready`=0 until `finish`.
- Same stream with random `in_valid` gaps, and `finish` pulsed during FILL -> identical writes; the stray `finish` has no effect.
- `finish` pulse in WAIT -> `busy` 0 and `index`=1; next sample writes `wr_addr` 8..15.
- Run 1024 samples -> after the last `finish`, `index` wraps to 0 and the next write targets `wr_addr` 0.
- Assert `rst` after 3 bytes of word 2 -> no `wr_en`, `index`=0, and the next 64 bytes write `wr_addr` 0..7 cleanly.
- With the macro: 64 bytes 0x01 plus trailer 0x40 -> `start` pulse.
  - The same sample with trailer 0x41 -> `err`=1, no `start`, and the resent sample rewrites `wr_addr` 0..7.
